// File: rtl/crossyroad_pkg.sv
// Shared definitions for the crossyroad game: move-button FSM states and
// default button timing constants (25 MHz pixel clock).
package crossyroad_pkg;

    // Move-button conditioner FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    // 10 ms debounce window at 25 MHz
    localparam int BTN_DEBOUNCE_CYCLES = 250000;

    // 0.5 s hold before auto-repeat kicks in
    localparam int BTN_HOLD_CYCLES     = 12500000;

    // 0.2 s auto-repeat period
    localparam int BTN_REPEAT_CYCLES   = 5000000;

    // Counter width needed to hold the largest default terminal count
    localparam int BTN_CNT_W           = 24;

endpackage : crossyroad_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous pad inputs.
// Both stages reset to 0 so a held pad looks like a fresh edge after reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // Two-stage shift: the first flop may go metastable, the second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule : sync_2ff

// File: rtl/move_btn_conditioner.sv
// Move-button conditioner: synchronises and debounces the raw pad, then
// emits single-cycle move strobes on press, after a hold delay, and at a
// fixed auto-repeat rate while held. Pulses can be masked by enable without
// disturbing the timing state.
module move_btn_conditioner
    import crossyroad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = BTN_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_CYCLES,
    parameter int CNT_W           = BTN_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic enable,
    output logic btn_level,
    output logic move_pulse,
    output logic repeat_active
);

    // Terminal counts; each counter clears on reaching its terminal value,
    // so none of them can ever wrap.
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             w_syncQ;
    logic             w_mismatch;
    logic             w_dbTerm;
    logic             w_levelRise;
    logic             w_levelFall;

    logic             r_btnLevel;
    logic [CNT_W-1:0] r_dbCnt;

    btn_state_t       r_state;
    btn_state_t       w_stateNext;
    logic [CNT_W-1:0] r_hrCnt;
    logic [CNT_W-1:0] w_hrCntNext;
    logic             w_pulseEvt;

    logic             r_movePulse;
    logic             r_repeatActive;

    sync_2ff u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (btn_raw),
        .o_sync  (w_syncQ)
    );

    // Debounce decode. The level edges are flagged one cycle early (on the
    // terminal count) so the FSM can react at the same edge that updates
    // btn_level, which makes the press pulse coincide with the level rise.
    always_comb begin
        w_mismatch  = (w_syncQ != r_btnLevel);
        w_dbTerm    = w_mismatch && (r_dbCnt == DB_LAST);
        w_levelRise = w_dbTerm && !r_btnLevel;
        w_levelFall = w_dbTerm && r_btnLevel;
    end

    // Debounce counter and accepted level: count consecutive disagreeing
    // cycles, toggle the level on terminal count, drop the count on agreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbCnt    <= '0;
            r_btnLevel <= 1'b0;
        end else if (!w_mismatch) begin
            r_dbCnt    <= '0;
        end else if (w_dbTerm) begin
            r_dbCnt    <= '0;
            r_btnLevel <= ~r_btnLevel;
        end else begin
            r_dbCnt    <= r_dbCnt + CNT_ONE;
        end
    end

    // Press / hold / repeat sequencing with one shared counter. A release
    // always wins over a terminal count landing in the same cycle.
    always_comb begin
        w_stateNext = r_state;
        w_hrCntNext = r_hrCnt;
        w_pulseEvt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_levelRise) begin
                    w_stateNext = ST_HELD;
                    w_hrCntNext = '0;
                    w_pulseEvt  = 1'b1;
                end
            end
            ST_HELD: begin
                if (w_levelFall) begin
                    w_stateNext = ST_IDLE;
                    w_hrCntNext = '0;
                end else if (r_hrCnt == HOLD_LAST) begin
                    w_stateNext = ST_REPEAT;
                    w_hrCntNext = '0;
                    w_pulseEvt  = 1'b1;
                end else begin
                    w_hrCntNext = r_hrCnt + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (w_levelFall) begin
                    w_stateNext = ST_IDLE;
                    w_hrCntNext = '0;
                end else if (r_hrCnt == REPEAT_LAST) begin
                    w_hrCntNext = '0;
                    w_pulseEvt  = 1'b1;
                end else begin
                    w_hrCntNext = r_hrCnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
                w_hrCntNext = '0;
            end
        endcase
    end

    // FSM state and hold/repeat counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hrCnt <= '0;
        end else begin
            r_state <= w_stateNext;
            r_hrCnt <= w_hrCntNext;
        end
    end

    // Registered outputs; enable only gates the strobe, so a masked event is
    // simply lost and the schedule carries on untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_movePulse    <= 1'b0;
            r_repeatActive <= 1'b0;
        end else begin
            r_movePulse    <= w_pulseEvt && enable;
            r_repeatActive <= (w_stateNext == ST_REPEAT);
        end
    end

    assign btn_level     = r_btnLevel;
    assign move_pulse    = r_movePulse;
    assign repeat_active = r_repeatActive;

endmodule : move_btn_conditioner

// File: tb/tb_move_btn_conditioner.sv
// Self-checking bench for move_btn_conditioner with small timing parameters.
// A reference model built on run lengths and time-since-press arithmetic is
// stepped alongside the DUT and compared after every clock edge.
module tb_move_btn_conditioner;

    localparam int D = 4;
    localparam int H = 10;
    localparam int R = 3;

    logic clk;
    logic rst_n;
    logic btnRaw;
    logic enable;
    logic btnLevel;
    logic movePulse;
    logic repeatActive;

    int checks;
    int failures;

    // Reference model state
    logic mS1, mSyncQ, mLevel, mPulse, mRepeat;
    int   mRun, mCycle, mPressT;

    // Scenario bookkeeping
    int stepCount, sceneBase, pulseCount, firstPulse;

    move_btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btnRaw),
        .enable        (enable),
        .btn_level     (btnLevel),
        .move_pulse    (movePulse),
        .repeat_active (repeatActive)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s at step %0d: observed=%0h expected=%0h", tag, stepCount, obs, exp);
        end
    endtask

    task automatic modelReset();
        mS1 = 0; mSyncQ = 0; mLevel = 0; mPulse = 0; mRepeat = 0;
        mRun = 0; mPressT = 0;
    endtask

    // Behaviour across one edge: level flips after D consecutive disagreeing
    // samples; pulses fall at t==0, t==H, then every R after H, where t is
    // the number of cycles since the accepted press.
    task automatic modelEdge(input logic raw, input logic en);
        logic rise, fall, newLevel, evt;
        int   t;
        mCycle++;
        rise = 0; fall = 0; evt = 0;
        if (mSyncQ != mLevel) begin
            mRun++;
            if (mRun == D) begin
                rise = !mLevel;
                fall = mLevel;
                mRun = 0;
            end
        end else begin
            mRun = 0;
        end
        newLevel = mLevel ^ (rise | fall);
        if (rise) begin
            mPressT = mCycle;
            evt = 1;
        end else if (newLevel) begin
            t = mCycle - mPressT;
            if (t == H || (t > H && ((t - H) % R) == 0)) evt = 1;
        end
        mRepeat = newLevel && ((mCycle - mPressT) >= H);
        mPulse  = evt && en;
        mSyncQ  = mS1;
        mS1     = raw;
        mLevel  = newLevel;
    endtask

    task automatic checkOutput();
        checkValue("btn_level", btnLevel, mLevel);
        checkValue("move_pulse", movePulse, mPulse);
        checkValue("repeat_active", repeatActive, mRepeat);
    endtask

    // One clock edge: capture pre-edge inputs, advance model, check 1 unit later
    task automatic step();
        logic rawPre, enPre, rstPre;
        rawPre = btnRaw; enPre = enable; rstPre = rst_n;
        @(posedge clk);
        if (!rstPre) begin
            modelReset();
            mCycle++;
        end else begin
            modelEdge(rawPre, enPre);
        end
        #1;
        checkOutput();
        stepCount++;
        if (movePulse === 1'b1) begin
            pulseCount++;
            if (firstPulse < 0) firstPulse = stepCount - sceneBase - 1;
        end
    endtask

    task automatic applyStimulus(input logic raw, input logic en, input int n);
        btnRaw = raw;
        enable = en;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic newScene();
        sceneBase  = stepCount;
        pulseCount = 0;
        firstPulse = -1;
    endtask

    initial begin
        checks = 0; failures = 0; stepCount = 0; mCycle = 0;
        rst_n = 1'b0; btnRaw = 1'b0; enable = 1'b1;
        modelReset();
        newScene();
        #1;

        // Reset state
        applyStimulus(1'b0, 1'b1, 3);
        checkValue("reset_level", btnLevel, 1'b0);
        checkValue("reset_pulse", movePulse, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 4);

        // Glitch rejection: three high samples never reach the debounce count
        $display("[TB] glitch rejection");
        newScene();
        applyStimulus(1'b1, 1'b1, 3);
        applyStimulus(1'b0, 1'b1, 12);
        checkValue("glitch_pulses", pulseCount, 0);

        // Clean press: press pulse after edge 5, hold pulse 10 later
        $display("[TB] clean press");
        newScene();
        applyStimulus(1'b1, 1'b1, 12);
        applyStimulus(1'b0, 1'b1, 12);
        checkValue("press_first", firstPulse, 5);
        checkValue("press_pulses", pulseCount, 2);

        // Auto-repeat: level high over edges 5..44, pulses 5,15,18,...,42
        $display("[TB] auto-repeat");
        newScene();
        applyStimulus(1'b1, 1'b1, 40);
        applyStimulus(1'b0, 1'b1, 12);
        checkValue("repeat_first", firstPulse, 5);
        checkValue("repeat_pulses", pulseCount, 11);

        // Enable mask: press pulse dropped, hold pulse at press+10 survives
        $display("[TB] enable mask");
        newScene();
        applyStimulus(1'b1, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 6);
        applyStimulus(1'b0, 1'b1, 12);
        checkValue("mask_first", firstPulse, 15);
        checkValue("mask_pulses", pulseCount, 2);

        // Release lands on the hold terminal count (edge 15): no hold pulse
        $display("[TB] release/terminal collision");
        newScene();
        applyStimulus(1'b1, 1'b1, 10);
        applyStimulus(1'b0, 1'b1, 12);
        checkValue("collide_first", firstPulse, 5);
        checkValue("collide_pulses", pulseCount, 1);

        // Async reset mid-REPEAT with the button held
        $display("[TB] async reset");
        newScene();
        applyStimulus(1'b1, 1'b1, 20);
        checkValue("pre_reset_repeat", repeatActive, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkValue("async_level", btnLevel, 1'b0);
        checkValue("async_pulse", movePulse, 1'b0);
        checkValue("async_repeat", repeatActive, 1'b0);
        applyStimulus(1'b1, 1'b1, 2);
        rst_n = 1'b1;
        newScene();
        applyStimulus(1'b1, 1'b1, 8);
        checkValue("post_reset_first", firstPulse, 5);
        applyStimulus(1'b0, 1'b1, 12);

        // Randomised segments of held/released pad with random enable
        $display("[TB] random segments");
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            len = $urandom_range(1, 30);
            btnRaw = ~btnRaw;
            for (int i = 0; i < len; i++) begin
                enable = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
                else rst_n = 1'b1;
                step();
            end
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_move_btn_conditioner
